// File: rtl/sync_pulse_monitor.sv
// Measures the distance between successive sync pulses, declares lock once the
// period settles, and flags loss of the pulse train after TIMEOUT quiet cycles.
module sync_pulse_monitor #(
  parameter int CNT_W      = 24,
  parameter int TIMEOUT    = 1000000,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [15:0]      pulse_count
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prev_period_q, prev_period_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             seeded_q, seeded_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      pulse_count_q, pulse_count_d;

  logic [CNT_W-1:0] diff;
  logic [3:0]       match_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      prev_period_q  <= '0;
      match_cnt_q    <= '0;
      seeded_q       <= 1'b0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      pulse_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prev_period_q  <= prev_period_d;
      match_cnt_q    <= match_cnt_d;
      seeded_q       <= seeded_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
      pulse_count_q  <= pulse_count_d;
    end
  end

  // seeded_q marks that prev_period holds a real period since the last IDLE exit
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prev_period_d  = prev_period_q;
    match_cnt_d    = match_cnt_q;
    seeded_d       = seeded_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;
    pulse_count_d  = pulse_count_q;
    match_next     = '0;

    diff = (cnt_q >= prev_period_q) ? (cnt_q - prev_period_q) : (prev_period_q - cnt_q);

    if (clear_stats) begin
      pulse_count_d = {15'd0, pulse_in};
    end else if (pulse_in) begin
      pulse_count_d = pulse_count_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pulse_in) begin
          state_d     = MEASURE;
          cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
          match_cnt_d = '0;
          seeded_d    = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      default: begin
        if (pulse_in) begin
          cnt_d          = {{(CNT_W-1){1'b0}}, 1'b1};
          period_out_d   = cnt_q;
          period_valid_d = 1'b1;
          prev_period_d  = cnt_q;
          seeded_d       = 1'b1;
          timeout_d      = 1'b0;
          if (seeded_q && (diff <= TOL_C)) begin
            match_next = (match_cnt_q >= LOCK_C) ? LOCK_C : (match_cnt_q + 4'd1);
          end
          match_cnt_d = match_next;
          if (match_next == LOCK_C) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d  = MEASURE;
            locked_d = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d     = IDLE;
          cnt_d       = '0;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign pulse_count  = pulse_count_q;

endmodule

// File: tb/tb_sync_pulse_monitor.sv
// Bench for sync_pulse_monitor: a timestamp-based model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sync_pulse_monitor;

  localparam int CNT_W      = 24;
  localparam int TIMEOUT    = 100;
  localparam int LOCK_COUNT = 4;
  localparam int TOL        = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pulse_in;
  logic             clear_stats;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [15:0]      pulse_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  sync_pulse_monitor #(
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .LOCK_COUNT(LOCK_COUNT),
    .TOL(TOL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pulse_in(pulse_in),
    .clear_stats(clear_stats),
    .period_out(period_out),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  // Model: remembers the timestamp of the last pulse and the last period,
  // and counts how many periods in a row agreed with their predecessor.
  int          t = 0;
  bit          m_active = 1'b0;
  int          m_last_t = 0;
  int          m_prev = -1;
  int          m_run = 0;
  int          m_per = 0;
  int          m_dist = 0;
  bit          m_locked = 1'b0;
  bit          m_timeout = 1'b0;
  bit          m_valid = 1'b0;
  int          m_period = 0;
  logic [15:0] m_count = '0;

  always @(posedge clk) begin
    t++;
    if (rst) begin
      m_active  = 1'b0;
      m_prev    = -1;
      m_run     = 0;
      m_locked  = 1'b0;
      m_timeout = 1'b0;
      m_valid   = 1'b0;
      m_period  = 0;
      m_count   = '0;
    end else begin
      m_valid = 1'b0;
      if (pulse_in) begin
        if (!m_active) begin
          m_active  = 1'b1;
          m_prev    = -1;
          m_run     = 0;
          m_timeout = 1'b0;
        end else begin
          m_per    = t - m_last_t;
          m_period = m_per;
          m_valid  = 1'b1;
          m_dist   = (m_per > m_prev) ? (m_per - m_prev) : (m_prev - m_per);
          if (m_prev >= 0 && m_dist <= TOL)
            m_run = (m_run < LOCK_COUNT) ? m_run + 1 : LOCK_COUNT;
          else
            m_run = 0;
          m_prev    = m_per;
          m_locked  = (m_run == LOCK_COUNT);
          m_timeout = 1'b0;
        end
        m_last_t = t;
      end else if (m_active && (t - m_last_t) == TIMEOUT) begin
        m_active  = 1'b0;
        m_timeout = 1'b1;
        m_locked  = 1'b0;
        m_run     = 0;
      end
      if (clear_stats)
        m_count = pulse_in ? 16'd1 : 16'd0;
      else if (pulse_in)
        m_count = m_count + 16'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("period_out", period_out, m_period);
      checkOutput("period_valid", period_valid, m_valid);
      checkOutput("locked", locked, m_locked);
      checkOutput("timeout", timeout, m_timeout);
      checkOutput("pulse_count", pulse_count, m_count);
    end
  end

  task automatic applyStimulus(input bit p, input bit c, input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in    = p;
      clear_stats = c;
      rst         = r;
      @(negedge clk);
    end
  endtask

  task automatic gapPulse(input int gap);
    applyStimulus(1'b0, 1'b0, 1'b0, gap - 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
  endtask

  logic [15:0] count_before;
  logic [15:0] count_exp;

  initial begin
    pulse_in    = 1'b0;
    clear_stats = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    check_en = 1'b1;
    checkOutput("reset_period_out", period_out, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_pulse_count", pulse_count, 0);

    $display("[TB] Scenario 1: six pulses every 50 cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("s1_first_no_valid", period_valid, 0);
    for (int k = 1; k <= 5; k++) begin
      gapPulse(50);
      if (k == 4) checkOutput("s1_not_yet_locked", locked, 0);
    end
    checkOutput("s1_period", period_out, 50);
    checkOutput("s1_valid", period_valid, 1);
    checkOutput("s1_locked", locked, 1);

    $display("[TB] Scenario 2: gaps 51, 49, 60 while locked");
    gapPulse(51);
    checkOutput("s2_p51", period_out, 51);
    checkOutput("s2_lock51", locked, 1);
    gapPulse(49);
    checkOutput("s2_lock49", locked, 1);
    gapPulse(60);
    checkOutput("s2_p60", period_out, 60);
    checkOutput("s2_valid60", period_valid, 1);
    checkOutput("s2_unlock60", locked, 0);

    $display("[TB] Scenario 3: relock then stop pulses");
    for (int k = 0; k < 4; k++) gapPulse(60);
    checkOutput("s3_relocked", locked, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 99);
    checkOutput("s3_no_timeout_99", timeout, 0);
    checkOutput("s3_still_locked_99", locked, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("s3_timeout_100", timeout, 1);
    checkOutput("s3_unlocked_100", locked, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("s3_timeout_cleared", timeout, 0);
    checkOutput("s3_no_valid", period_valid, 0);

    $display("[TB] Scenario 4: pulse on the timeout cycle");
    gapPulse(100);
    checkOutput("s4_no_timeout", timeout, 0);
    checkOutput("s4_period", period_out, 100);
    checkOutput("s4_valid", period_valid, 1);

    $display("[TB] Scenario 5: pulse_in held high for 10 cycles");
    applyStimulus(1'b0, 1'b0, 1'b0, 110);
    checkOutput("s5_timed_out", timeout, 1);
    count_before = pulse_count;
    applyStimulus(1'b1, 1'b0, 1'b0, 5);
    checkOutput("s5_period1", period_out, 1);
    checkOutput("s5_not_locked", locked, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5);
    count_exp = count_before + 16'd10;
    checkOutput("s5_locked", locked, 1);
    checkOutput("s5_valid", period_valid, 1);
    checkOutput("s5_count", pulse_count, count_exp);

    $display("[TB] Scenario 6: reset while locked, clear_stats");
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("s6_rst_valid", period_valid, 0);
    checkOutput("s6_rst_locked", locked, 0);
    checkOutput("s6_rst_period", period_out, 0);
    checkOutput("s6_rst_count", pulse_count, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("s6_count3", pulse_count, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("s6_clear", pulse_count, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("s6_clear_with_pulse", pulse_count, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
